// File: rtl/demux1_4_reg.sv
// demux1_4_reg: registered 1-to-4 stream demultiplexer.
// One producer word per cycle is steered by in_sel into one of four
// single-entry channel registers (a..d), each with its own valid/ready
// handshake and a wrapping count of words delivered to its consumer.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready producer handshake
//   in_sel, in_data   target channel (0=a..3=d) and word
//   out_valid[3:0]    per-channel word held (bit0=a .. bit3=d)
//   out_ready[3:0]    per-channel consumer accepts
//   out_a..out_d      channel holding registers
//   cnt_a..cnt_d      per-channel delivered-word counters
//   busy              any channel holding a word
module demux1_4_reg #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_c,
   output logic [WIDTH-1:0] out_d,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b,
   output logic [CNT_W-1:0] cnt_c,
   output logic [CNT_W-1:0] cnt_d,
   output logic             busy
);

   localparam logic [0:0] S_EMPTY = 1'b0;
   localparam logic [0:0] S_FULL  = 1'b1;

   logic             in_fire;
   logic [3:0]       load;
   logic [3:0]       drain;
   logic [WIDTH-1:0] dout [4];
   logic [CNT_W-1:0] cnt  [4];

   // Only the selected channel decides acceptance; a full channel
   // that is draining this edge can take a new word (full throughput).
   assign in_ready = !out_valid[in_sel] | out_ready[in_sel];
   assign in_fire  = in_valid & in_ready;

   for (genvar i = 0; i < 4; i++) begin : g_ch
      logic [0:0]       state_q;
      logic [0:0]       state_d;
      logic [WIDTH-1:0] data_q;
      logic [WIDTH-1:0] data_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      assign out_valid[i] = (state_q == S_FULL);
      assign load[i]      = in_fire & (in_sel == 2'(i));
      // ready on an empty channel is ignored
      assign drain[i]     = out_valid[i] & out_ready[i];

      always_comb begin
         state_d = state_q;
         case (state_q)
            S_EMPTY: begin
               if (load[i]) state_d = S_FULL;
            end
            S_FULL: begin
               if (drain[i] && !load[i]) state_d = S_EMPTY;
            end
         endcase
      end

      // data is kept when the channel empties
      assign data_d = load[i]  ? in_data : data_q;
      assign cnt_d  = drain[i] ? cnt_q + CNT_W'(1) : cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
         end
      end

      assign dout[i] = data_q;
      assign cnt[i]  = cnt_q;
   end

   assign out_a = dout[0];
   assign out_b = dout[1];
   assign out_c = dout[2];
   assign out_d = dout[3];
   assign cnt_a = cnt[0];
   assign cnt_b = cnt[1];
   assign cnt_c = cnt[2];
   assign cnt_d = cnt[3];
   assign busy  = |out_valid;

endmodule

// File: tb/tb_demux1_4_reg.sv
// tb_demux1_4_reg: directed bench for demux1_4_reg.
// Expected words are queued on acceptance and popped on delivery.
module tb_demux1_4_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_sel;
   logic [31:0] in_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_a, out_b, out_c, out_d;
   logic [7:0]  cnt_a, cnt_b, cnt_c, cnt_d;
   logic        busy;

   demux1_4_reg #(.WIDTH(32), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
      .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ch;
      logic [31:0] data;
   } sb_t;

   sb_t        sb[$];
   logic [3:0] mv;
   logic [7:0] mcnt [4];
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dut_out(input logic [1:0] ch);
      case (ch)
         2'd0: return out_a;
         2'd1: return out_b;
         2'd2: return out_c;
         default: return out_d;
      endcase
   endfunction

   function automatic logic [7:0] dut_cnt(input int ch);
      case (ch)
         0: return cnt_a;
         1: return cnt_b;
         2: return cnt_c;
         default: return cnt_d;
      endcase
   endfunction

   task automatic pop_cmp(input logic [1:0] ch);
      int idx = -1;
      foreach (sb[k]) if (idx < 0 && sb[k].ch == ch) idx = k;
      if (idx < 0) begin
         checks++;
         errors++;
         $error("FAIL sb_pop ch=%0d observed=empty expected=entry", ch);
      end else begin
         chk($sformatf("deliver_ch%0d", ch), dut_out(ch), sb[idx].data);
         sb.delete(idx);
      end
   endtask

   task automatic model_reset();
      mv = '0;
      for (int i = 0; i < 4; i++) mcnt[i] = '0;
      sb.delete();
   endtask

   task automatic check_state();
      chk("out_valid", 32'(out_valid), 32'(mv));
      chk("busy", 32'(busy), 32'(|mv));
      for (int i = 0; i < 4; i++)
         chk($sformatf("cnt_%0d", i), 32'(dut_cnt(i)), 32'(mcnt[i]));
   endtask

   // Entered just after a rising edge with inputs already driven.
   task automatic cycle();
      logic exp_rdy;
      logic fire;
      #3;
      exp_rdy = !mv[in_sel] | out_ready[in_sel];
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      fire = in_valid & exp_rdy;
      for (int i = 0; i < 4; i++) begin
         if (mv[i] && out_ready[i]) begin
            pop_cmp(2'(i));
            mcnt[i] = mcnt[i] + 8'd1;
            mv[i] = 1'b0;
         end
      end
      if (fire) begin
         sb.push_back('{ch: in_sel, data: in_data});
         mv[in_sel] = 1'b1;
      end
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic drive(input logic v, input logic [1:0] s,
                        input logic [31:0] d, input logic [3:0] r);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
   endtask

   initial begin
      model_reset();
      rst_n = 1'b0;
      drive(1'b0, 2'd0, 32'h0, 4'h0);
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_out_a", out_a, 32'h0);
      chk("rst_cnt_d", 32'(cnt_d), 32'h0);
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'h1);

      // basic route to c
      drive(1'b1, 2'd2, 32'hDEAD_BEEF, 4'h0);
      cycle();
      chk("route_out_c", out_c, 32'hDEAD_BEEF);
      chk("route_out_a", out_a, 32'h0);
      chk("route_out_d", out_d, 32'h0);

      // back-pressure on c
      drive(1'b1, 2'd2, 32'h5555_5555, 4'h0);
      cycle();
      chk("bp_out_c_hold", out_c, 32'hDEAD_BEEF);

      // switch to a while c stalls
      drive(1'b1, 2'd0, 32'h1, 4'h0);
      cycle();
      chk("sw_out_a", out_a, 32'h1);

      // back-to-back on b
      drive(1'b1, 2'd1, 32'hA, 4'h0);
      cycle();
      drive(1'b1, 2'd1, 32'hB, 4'b0010);
      cycle();
      chk("b2b_out_b", out_b, 32'hB);
      chk("b2b_cnt_b", 32'(cnt_b), 32'h1);

      // fill d, then drain all four in parallel
      drive(1'b1, 2'd3, 32'hD, 4'h0);
      cycle();
      chk("all_full", 32'(out_valid), 32'hF);
      drive(1'b0, 2'd0, 32'h0, 4'hF);
      cycle();
      chk("drain_busy", 32'(busy), 32'h0);
      chk("drain_hold_c", out_c, 32'hDEAD_BEEF);

      // ready on empty channels is ignored
      drive(1'b0, 2'd1, 32'h0, 4'hF);
      cycle();

      // 255 more deliveries to d wrap its counter to 0
      for (int i = 0; i < 255; i++) begin
         drive(1'b1, 2'd3, 32'(32'h100 + i), 4'b1000);
         cycle();
      end
      drive(1'b0, 2'd3, 32'h0, 4'b1000);
      cycle();
      chk("wrap_cnt_d", 32'(cnt_d), 32'h0);
      chk("wrap_cnt_a", 32'(cnt_a), 32'h1);

      // async reset mid-cycle with a and c full
      drive(1'b1, 2'd0, 32'h77, 4'h0);
      cycle();
      drive(1'b1, 2'd2, 32'h99, 4'h0);
      cycle();
      chk("pre_rst_valid", 32'(out_valid), 32'h5);
      drive(1'b0, 2'd0, 32'h0, 4'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_cnt_a", 32'(cnt_a), 32'h0);
      chk("mid_rst_cnt_c", 32'(cnt_c), 32'h0);
      chk("mid_rst_out_c", out_c, 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      model_reset();
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'h1);
      drive(1'b1, 2'd1, 32'hCAFE, 4'h0);
      cycle();
      chk("post_rst_out_b", out_b, 32'hCAFE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=done");
      $fatal(1, "timeout");
   end

endmodule
